// File: rtl/ahb_wrap_cache_if.sv
// rtl/ahb_wrap_cache_if.sv - cache line fetch/writeback bursts onto AHB; macro AHB_WRAP_BURST_EN selects critical-beat-first WRAP fetches
module ahb_wrap_cache_if #(
    parameter int AHBW         = 64,
    parameter int PA_BITS      = 56,
    parameter int BEATSPERLINE = 8,
    localparam int LINELEN     = AHBW * BEATSPERLINE,
    localparam int BCW         = $clog2(BEATSPERLINE)
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HREADY,
    input  logic               HRESP,
    input  logic [AHBW-1:0]    HRDATA,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [2:0]         HSIZE,
    output logic [2:0]         HBURST,
    output logic [PA_BITS-1:0] HADDR,
    output logic [AHBW-1:0]    HWDATA,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [1:0]         CacheBusRW,
    input  logic [AHBW-1:0]    CacheWriteBeat,
    input  logic               Flush,
    output logic [BCW-1:0]     BeatCount,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic               CritValid,
    output logic               CacheBusAck,
    output logic               CacheBusErr,
    output logic               BusStall
);
    localparam int OFF = $clog2(AHBW / 8);
    localparam logic [2:0] INCR_CODE = (BEATSPERLINE == 4) ? 3'b011 :
                                       (BEATSPERLINE == 8) ? 3'b101 : 3'b111;
    localparam logic [2:0] WRAP_CODE = (BEATSPERLINE == 4) ? 3'b010 :
                                       (BEATSPERLINE == 8) ? 3'b100 : 3'b110;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
    state_t state, state_n;

    logic           req, fetch_c, dphase_done, err_now;
    logic           is_fetch, data_valid, err_r;
    logic [BCW-1:0] start_c, addr_beat, data_beat, data_cnt;
    logic [BCW:0]   issued;

    assign req         = (CacheBusRW != 2'b00) && !Flush;
    assign dphase_done = data_valid && HREADY;
    assign err_now     = data_valid && HRESP;
    assign fetch_c     = (state == IDLE) ? CacheBusRW[1] : is_fetch;

`ifdef AHB_WRAP_BURST_EN
    logic [BCW-1:0] crit_beat;
    logic           crit_r;
    logic           unused_adr;
    assign unused_adr = ^CacheBusAdr[OFF-1:0];
    assign start_c    = (req && CacheBusRW[1]) ? CacheBusAdr[OFF +: BCW] : '0;
    assign HBURST     = fetch_c ? WRAP_CODE : INCR_CODE;
    assign CritValid  = crit_r;
`else
    logic unused_adr;
    assign unused_adr = ^CacheBusAdr[OFF+BCW-1:0];
    assign start_c    = '0;
    assign HBURST     = INCR_CODE;
    // Without wrapping the critical beat is not known early, so restart waits for the whole line.
    assign CritValid  = (state == DONE) && is_fetch && !err_r;
`endif

    assign HSIZE       = (AHBW == 64) ? 3'b011 : 3'b010;
    assign HADDR       = {CacheBusAdr[PA_BITS-1:OFF+BCW], BeatCount, {OFF{1'b0}}};
    assign CacheBusAck = (state == DONE);
    assign CacheBusErr = (state == DONE) && err_r;
    assign BusStall    = (state != IDLE) || req;

    always_comb begin
        state_n   = state;
        HTRANS    = 2'b00;
        HWRITE    = 1'b0;
        BeatCount = addr_beat;
        case (state)
            IDLE: begin
                BeatCount = start_c;
                HWRITE    = CacheBusRW[0];
                if (req) begin
                    HTRANS = 2'b10;
                    if (HREADY) state_n = CacheBusRW[1] ? FETCH : WRITE;
                end
            end
            FETCH, WRITE: begin
                HWRITE = !is_fetch;
                if (issued < (BCW+1)'(BEATSPERLINE)) HTRANS = 2'b11;
                if (err_now) state_n = DONE;
                else if (dphase_done && data_cnt == BCW'(BEATSPERLINE - 1)) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= IDLE;
            is_fetch    <= 1'b0;
            addr_beat   <= '0;
            issued      <= '0;
            data_cnt    <= '0;
            data_beat   <= '0;
            data_valid  <= 1'b0;
            err_r       <= 1'b0;
            HWDATA      <= '0;
            FetchBuffer <= '0;
`ifdef AHB_WRAP_BURST_EN
            crit_beat   <= '0;
            crit_r      <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                if (req && HREADY) begin
                    is_fetch  <= CacheBusRW[1];
                    addr_beat <= start_c + BCW'(1);
                    issued    <= (BCW+1)'(1);
                    data_cnt  <= '0;
                    err_r     <= 1'b0;
`ifdef AHB_WRAP_BURST_EN
                    crit_beat <= start_c;
`endif
                end
            end else if (state != DONE) begin
                if (HTRANS[1] && HREADY) begin
                    addr_beat <= addr_beat + BCW'(1);
                    issued    <= issued + (BCW+1)'(1);
                end
                if (dphase_done) data_cnt <= data_cnt + BCW'(1);
                if (err_now) err_r <= 1'b1;
            end
            // Data-phase tracker trails the address phase by one accepted beat.
            if (err_now) begin
                data_valid <= 1'b0;
            end else if (HREADY) begin
                data_valid <= HTRANS[1];
                data_beat  <= BeatCount;
            end
            if (HREADY && HTRANS[1] && HWRITE) HWDATA <= CacheWriteBeat;
            if (state == FETCH && dphase_done && !HRESP)
                FetchBuffer[int'(data_beat)*AHBW +: AHBW] <= HRDATA;
`ifdef AHB_WRAP_BURST_EN
            crit_r <= (state == FETCH) && dphase_done && !HRESP && (data_beat == crit_beat);
`endif
        end
    end
endmodule

// File: tb/tb_ahb_wrap_cache_if.sv
// tb/tb_ahb_wrap_cache_if.sv - directed self-checking bench for ahb_wrap_cache_if
module tb_ahb_wrap_cache_if;
    localparam int AHBW = 64, PA = 56, BPL = 8, LL = AHBW * BPL, BCW = 3;
`ifdef AHB_WRAP_BURST_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic            clk, rst_n, hready, hresp, hwrite, flush;
    logic [AHBW-1:0] hrdata, hwdata, wbeat;
    logic [1:0]      htrans, rw;
    logic [2:0]      hsize, hburst;
    logic [PA-1:0]   haddr, adr;
    logic [BCW-1:0]  beat_count;
    logic [LL-1:0]   fetch_buffer;
    logic            crit_valid, ack, err, stall;

    ahb_wrap_cache_if dut (
        .HCLK(clk), .HRESETn(rst_n), .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HADDR(haddr),
        .HWDATA(hwdata), .CacheBusAdr(adr), .CacheBusRW(rw), .CacheWriteBeat(wbeat),
        .Flush(flush), .BeatCount(beat_count), .FetchBuffer(fetch_buffer),
        .CritValid(crit_valid), .CacheBusAck(ack), .CacheBusErr(err), .BusStall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    task automatic check_val(input string tag, input logic [LL-1:0] obs, input logic [LL-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AHBW-1:0] pat_w(input int b);
        return 64'hA5A5_0000_0000_0000 | AHBW'(b);
    endfunction
    function automatic logic [AHBW-1:0] pat_r(input logic [PA-1:0] a);
        return 64'hF00D_0000_0000_0000 | AHBW'(a);
    endfunction

    logic [PA-1:0]   acc_addr[$];
    logic [AHBW-1:0] wr_data[$];
    int              crit_cyc, ack_cyc;
    logic            ack_err, got_ack, write0, stall0;
    logic [1:0]      trans0, trans_ack;
    logic [2:0]      burst0;

    // Plays the slave and the cache for one transaction; cycle 0 is the request cycle.
    task automatic run_txn(input logic [1:0] t_rw, input logic [PA-1:0] t_adr, input int stall_ord,
                           input int stall_len, input int err_ord, input int abort_ord);
        int cyc = 0, stalled = 0, ndata = 0;
        logic pend = 1'b0, stall_cyc;
        logic [PA-1:0] pend_addr = '0;
        acc_addr.delete(); wr_data.delete();
        crit_cyc = -1; ack_cyc = -1; got_ack = 1'b0; ack_err = 1'b0; trans_ack = 2'bxx;
        rw = t_rw; adr = t_adr;
        while (cyc < 40) begin
            hready = 1'b1; hresp = 1'b0; stall_cyc = 1'b0;
            hrdata = pend ? pat_r(pend_addr) : '0;
            if (pend && ndata == err_ord) begin
                hresp = 1'b1; hready = 1'b0;
            end else if (acc_addr.size() == stall_ord && stalled < stall_len) begin
                hready = 1'b0; stalled++; stall_cyc = 1'b1;
            end
            @(negedge clk);
            if (abort_ord >= 0 && acc_addr.size() == abort_ord) return;
            if (cyc == 0) begin
                trans0 = htrans; burst0 = hburst; write0 = hwrite; stall0 = stall;
            end
            if (stall_cyc) begin
                check_val("stall_haddr", LL'(haddr), LL'(t_adr + PA'(8 * stall_ord)));
                check_val("stall_hwdata", LL'(hwdata), LL'(pat_w(stall_ord - 1)));
            end
            if (pend && hready) begin
                if (t_rw == 2'b01) wr_data.push_back(hwdata);
                ndata++;
            end
            if (htrans != 2'b00 && hready) begin
                acc_addr.push_back(haddr); pend = 1'b1; pend_addr = haddr;
            end else if (hready) begin
                pend = 1'b0;
            end
            if (crit_valid && crit_cyc < 0) crit_cyc = cyc;
            if (ack) begin
                got_ack = 1'b1; ack_cyc = cyc; ack_err = err; trans_ack = htrans;
            end
            wbeat = pat_w(int'(beat_count));
            @(posedge clk); #1;
            if (got_ack) begin
                rw = 2'b00; hready = 1'b1; hresp = 1'b0;
                break;
            end
            cyc++;
        end
    endtask

    task automatic check_fetch(input string tag, input logic [PA-1:0] t_adr);
        int crit;
        logic [PA-1:0] base, ea;
        logic [LL-1:0] exp_buf;
        crit = int'(t_adr[5:3]);
        base = {t_adr[PA-1:6], 6'b0};
        check_val({tag, "_trans0"}, LL'(trans0), LL'(2'b10));
        check_val({tag, "_burst"}, LL'(burst0), WRAP ? LL'(3'b100) : LL'(3'b101));
        check_val({tag, "_naddr"}, LL'(acc_addr.size()), LL'(BPL));
        for (int i = 0; i < BPL && i < acc_addr.size(); i++) begin
            ea = base + PA'(8 * (WRAP ? (crit + i) % BPL : i));
            check_val({tag, "_haddr"}, LL'(acc_addr[i]), LL'(ea));
        end
        check_val({tag, "_ack_cyc"}, LL'(ack_cyc), LL'(9));
        check_val({tag, "_crit_cyc"}, LL'(crit_cyc), WRAP ? LL'(2) : LL'(9));
        check_val({tag, "_err"}, LL'(ack_err), LL'(0));
        for (int i = 0; i < BPL; i++) exp_buf[i*AHBW +: AHBW] = pat_r(base + PA'(8 * i));
        check_val({tag, "_line"}, fetch_buffer, exp_buf);
    endtask

    initial begin
        rst_n = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = '0; adr = '0; rw = 2'b00;
        wbeat = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_htrans", LL'(htrans), LL'(0));
        check_val("rst_beat", LL'(beat_count), LL'(0));
        check_val("rst_ack", LL'({ack, err, crit_valid}), LL'(0));
        check_val("rst_hwdata", LL'(hwdata), LL'(0));
        check_val("rst_line", fetch_buffer, LL'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        flush = 1'b1; rw = 2'b10; adr = 56'h1028;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("flush_htrans", LL'(htrans), LL'(0));
            check_val("flush_stall", LL'(stall), LL'(0));
        end
        @(posedge clk); #1 flush = 1'b0; rw = 2'b00;

        run_txn(2'b10, 56'h1028, -1, 0, -1, -1);
        check_fetch("fetch1028", 56'h1028);

        run_txn(2'b01, 56'h2000, 3, 2, -1, -1);
        check_val("wb_hwrite", LL'(write0), LL'(1));
        check_val("wb_burst", LL'(burst0), LL'(3'b101));
        check_val("wb_naddr", LL'(acc_addr.size()), LL'(BPL));
        check_val("wb_nwrites", LL'(wr_data.size()), LL'(BPL));
        for (int i = 0; i < BPL && i < acc_addr.size(); i++)
            check_val("wb_haddr", LL'(acc_addr[i]), LL'(56'h2000 + PA'(8 * i)));
        for (int i = 0; i < BPL && i < wr_data.size(); i++)
            check_val("wb_hwdata", LL'(wr_data[i]), LL'(pat_w(i)));
        check_val("wb_ack_cyc", LL'(ack_cyc), LL'(11));
        check_val("wb_err", LL'(ack_err), LL'(0));

        run_txn(2'b10, 56'h5000, -1, 0, 2, -1);
        check_val("err_naddr", LL'(acc_addr.size()), LL'(3));
        check_val("err_ack_cyc", LL'(ack_cyc), LL'(4));
        check_val("err_flag", LL'(ack_err), LL'(1));
        check_val("err_htrans", LL'(trans_ack), LL'(0));
        @(negedge clk);
        check_val("err_idle_htrans", LL'(htrans), LL'(0));
        @(posedge clk); #1;

        run_txn(2'b10, 56'h6010, -1, 0, -1, 4);
        check_val("pre_rst_busy", LL'(stall), LL'(1));
        #2 rst_n = 1'b0; rw = 2'b00;
        #1;
        check_val("arst_htrans", LL'(htrans), LL'(0));
        check_val("arst_beat", LL'(beat_count), LL'(0));
        check_val("arst_flags", LL'({ack, err, crit_valid, stall}), LL'(0));
        check_val("arst_line", fetch_buffer, LL'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(2'b10, 56'h4030, -1, 0, -1, -1);
        check_val("post_rst_stall0", LL'(stall0), LL'(1));
        check_fetch("fetch4030", 56'h4030);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
